// File: rtl/decode_redirect_stage.sv
// decode_redirect_stage: resolves JAL/conditional branches in decode, drives the
// redirect controls back to fetch, squashes wrong-path slots after a redirect,
// and holds the ID/EX pipeline register.
// Optional feature macro: DECODE_MISALIGN_CHECK_EN (misaligned-target suppression).
module decode_redirect_stage #(
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR     = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [63:0] PCD,
    input  logic [63:0] PCPlus4D,
    input  logic [63:0] RD1D,
    input  logic [63:0] RD2D,
    output logic        PCSrcD,
    output logic        JalD,
    output logic [63:0] PCTargetD,
    output logic [31:0] InstrE,
    output logic [63:0] PCE,
    output logic [63:0] PCPlus4E,
    output logic [63:0] RD1E,
    output logic [63:0] RD2E,
    output logic [63:0] ImmE,
    output logic        ValidE,
    output logic        MisalignE
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned CNT_W = 3;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_b;
    logic            is_j;
    logic            taken;
    logic            slot_valid;
    logic            redirect;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] target_c;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ILEN-1:0]  instr_q;
    logic [XLEN-1:0]  pc_q, pc4_q, rd1_q, rd2_q, imm_q;
    logic             valid_q;

    assign opcode     = InstrD[6:0];
    assign funct3     = InstrD[14:12];
    assign is_b       = (opcode == OP_BRANCH);
    assign is_j       = (opcode == OP_JAL);
    assign slot_valid = (cnt_q == '0);

    assign b_imm = {{51{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                    InstrD[11:8], 1'b0};
    assign j_imm = {{43{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                    InstrD[30:21], 1'b0};

    // Immediate selection by instruction format.
    always_comb begin
        imm_c = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR:
                imm_c = {{52{InstrD[31]}}, InstrD[31:20]};
            OP_STORE:
                imm_c = {{52{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            OP_BRANCH:
                imm_c = b_imm;
            OP_LUI, OP_AUIPC:
                imm_c = {{32{InstrD[31]}}, InstrD[31:12], 12'h000};
            OP_JAL:
                imm_c = j_imm;
            default:
                imm_c = '0;
        endcase
    end

    // Branch condition evaluation; funct3 010/011 never take.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (RD1D == RD2D);
            3'b001:  taken = (RD1D != RD2D);
            3'b100:  taken = ($signed(RD1D) <  $signed(RD2D));
            3'b101:  taken = ($signed(RD1D) >= $signed(RD2D));
            3'b110:  taken = (RD1D <  RD2D);
            3'b111:  taken = (RD1D >= RD2D);
            default: taken = 1'b0;
        endcase
    end

    // Redirect target; zero for opcodes that cannot redirect.
    always_comb begin
        target_c = '0;
        if (is_b) begin
            target_c = PCD + b_imm;
        end else if (is_j) begin
            target_c = PCD + j_imm;
        end
    end

    assign PCTargetD = target_c;

`ifdef DECODE_MISALIGN_CHECK_EN
    logic misalign_c;
    logic misalign_q;

    // A would-be redirect to a non-word-aligned target is dropped and flagged.
    assign misalign_c = slot_valid & ((is_b & taken) | is_j) & target_c[1];
    assign PCSrcD     = slot_valid & is_b & taken & ~target_c[1];
    assign JalD       = slot_valid & is_j & ~target_c[1];

    // Misalign flag travels with its slot into ID/EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_c;
        end
    end

    assign MisalignE = misalign_q;
`else
    assign PCSrcD    = slot_valid & is_b & taken;
    assign JalD      = slot_valid & is_j;
    assign MisalignE = 1'b0;
`endif

    assign redirect = PCSrcD | JalD;

    // Squash counter: load on redirect, count down to zero otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (redirect) begin
            cnt_d = CNT_W'(SQUASH_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Squash counter register; reset aborts any squash in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ID/EX register: squashed slots become NOPs but keep PC and operand data.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q  <= PCD;
            pc4_q <= PCPlus4D;
            rd1_q <= RD1D;
            rd2_q <= RD2D;
            if (slot_valid) begin
                instr_q <= InstrD;
                imm_q   <= imm_c;
                valid_q <= 1'b1;
            end else begin
                instr_q <= NOP_INSTR;
                imm_q   <= '0;
                valid_q <= 1'b0;
            end
        end
    end

    assign InstrE   = instr_q;
    assign PCE      = pc_q;
    assign PCPlus4E = pc4_q;
    assign RD1E     = rd1_q;
    assign RD2E     = rd2_q;
    assign ImmE     = imm_q;
    assign ValidE   = valid_q;

endmodule
